// File: rtl/gp_switch_conditioner.sv
// Switch input conditioner: two-flop synchroniser, per-bit debounce counter,
// rise/fall pulses, sticky change flags and a masked, registered change IRQ.
module gp_switch_conditioner #(
    parameter int unsigned          NUM_SW          = 16,
    parameter int unsigned          DEBOUNCE_CYCLES = 50000,
    parameter logic [NUM_SW-1:0]    RESET_VAL       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_pin_i,
    input  logic [NUM_SW-1:0] irq_mask_i,
    input  logic              irq_clear_i,
    output logic [NUM_SW-1:0] sw_stable_o,
    output logic [NUM_SW-1:0] sw_rise_o,
    output logic [NUM_SW-1:0] sw_fall_o,
    output logic [NUM_SW-1:0] sw_change_o,
    output logic              sw_irq_o
);

    localparam int unsigned CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] s1_q, s2_q;
    logic [NUM_SW-1:0] stable_q, stable_d;
    logic [NUM_SW-1:0] rise_q, rise_d;
    logic [NUM_SW-1:0] fall_q, fall_d;
    logic [NUM_SW-1:0] change_q, change_d;
    logic [NUM_SW-1:0] accept;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  cnt_q [NUM_SW];
    logic [CNT_W-1:0]  cnt_d [NUM_SW];

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        accept   = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_SW; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
                accept[i]   = 1'b1;
                rise_d[i]   = s2_q[i];
                fall_d[i]   = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // A new accept on a bit wins over a coincident clear.
        change_d = (irq_clear_i ? '0 : change_q) | accept;
        irq_d    = |(change_q & irq_mask_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= RESET_VAL;
            s2_q     <= RESET_VAL;
            stable_q <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= sw_pin_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_stable_o = stable_q;
    assign sw_rise_o   = rise_q;
    assign sw_fall_o   = fall_q;
    assign sw_change_o = change_q;
    assign sw_irq_o    = irq_q;

endmodule

// File: tb/tb_gp_switch_conditioner.sv
// Directed bench for gp_switch_conditioner with DEBOUNCE_CYCLES = 4 (6-edge latency).
module tb_gp_switch_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_pin_i;
    logic [15:0] irq_mask_i;
    logic        irq_clear_i;
    logic [15:0] sw_stable_o, sw_rise_o, sw_fall_o, sw_change_o;
    logic        sw_irq_o;

    int checks = 0;
    int errors = 0;

    gp_switch_conditioner #(
        .NUM_SW          (16),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_pin_i    (sw_pin_i),
        .irq_mask_i  (irq_mask_i),
        .irq_clear_i (irq_clear_i),
        .sw_stable_o (sw_stable_o),
        .sw_rise_o   (sw_rise_o),
        .sw_fall_o   (sw_fall_o),
        .sw_change_o (sw_change_o),
        .sw_irq_o    (sw_irq_o)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] st, input logic [15:0] ri,
                           input logic [15:0] fa, input logic [15:0] ch, input logic irq);
        chk({tag, ".stable"}, sw_stable_o, st);
        chk({tag, ".rise"}, sw_rise_o, ri);
        chk({tag, ".fall"}, sw_fall_o, fa);
        chk({tag, ".change"}, sw_change_o, ch);
        chk({tag, ".irq"}, {15'b0, sw_irq_o}, {15'b0, irq});
    endtask

    initial begin
        rst         = 1'b1;
        sw_pin_i    = 16'h0000;
        irq_mask_i  = 16'hFFFF;
        irq_clear_i = 1'b0;

        // 1: reset, then quiet inputs
        tick();
        tick();
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_all("idle", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end

        // 2: bit 3 rise, accepted on the 6th edge
        sw_pin_i = 16'h0008;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("b3_wait", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        tick();
        chk_all("b3_accept", 16'h0008, 16'h0008, 16'h0000, 16'h0008, 1'b0);
        tick();
        chk_all("b3_irq", 16'h0008, 16'h0000, 16'h0000, 16'h0008, 1'b1);

        // 3: bit 5 bounce 1,1,1,0 never reaches four consecutive disagreements
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                sw_pin_i = (k == 3) ? 16'h0008 : 16'h0028;
                tick();
                chk("b5_bounce.stable", sw_stable_o, 16'h0008);
                chk("b5_bounce.rise", sw_rise_o, 16'h0000);
            end
        end
        sw_pin_i = 16'h0028;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("b5_hold.stable", sw_stable_o, 16'h0008);
            chk("b5_hold.rise", sw_rise_o, 16'h0000);
        end
        tick();
        chk_all("b5_accept", 16'h0028, 16'h0020, 16'h0000, 16'h0028, 1'b1);

        // 4: clear coincident with bit 7 accept
        sw_pin_i = 16'h00A8;
        for (int k = 1; k <= 5; k++) tick();
        chk("b7_pre.stable", sw_stable_o, 16'h0028);
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        chk_all("b7_clear_accept", 16'h00A8, 16'h0080, 16'h0000, 16'h0080, 1'b1);
        tick();
        chk_all("b7_after", 16'h00A8, 16'h0000, 16'h0000, 16'h0080, 1'b1);

        // 5: masked change on bit 0, then unmask
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        irq_mask_i  = 16'h0000;
        chk("clr.change", sw_change_o, 16'h0000);
        tick();
        chk("clr.irq", {15'b0, sw_irq_o}, 16'h0000);
        sw_pin_i = 16'h00A9;
        for (int k = 1; k <= 5; k++) tick();
        chk("b0_pre.change", sw_change_o, 16'h0000);
        tick();
        chk_all("b0_accept", 16'h00A9, 16'h0001, 16'h0000, 16'h0001, 1'b0);
        tick();
        chk("b0_masked.irq", {15'b0, sw_irq_o}, 16'h0000);
        tick();
        chk("b0_masked2.irq", {15'b0, sw_irq_o}, 16'h0000);
        irq_mask_i = 16'h0001;
        tick();
        chk("b0_unmask.irq", {15'b0, sw_irq_o}, 16'h0001);

        // 6a: bit 3 fall exercises the fall pulse
        sw_pin_i = 16'h00A1;
        for (int k = 1; k <= 5; k++) tick();
        chk("b3f_pre.fall", sw_fall_o, 16'h0000);
        tick();
        chk_all("b3_fall", 16'h00A1, 16'h0000, 16'h0008, 16'h0009, 1'b1);

        // 6b: bit 9 partial count discarded by reset
        irq_mask_i = 16'hFFFF;
        sw_pin_i   = 16'h02A1;
        for (int k = 1; k <= 5; k++) tick();
        chk("b9_partial.stable", sw_stable_o, 16'h00A1);
        sw_pin_i = 16'h0200;
        rst      = 1'b1;
        tick();
        chk_all("b9_rst1", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        chk_all("b9_rst2", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("b9_post", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        end
        tick();
        chk_all("b9_accept", 16'h0200, 16'h0200, 16'h0000, 16'h0200, 1'b0);
        tick();
        chk_all("b9_irq", 16'h0200, 16'h0000, 16'h0000, 16'h0200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
